sc_config_shadow_regs: RTL and testbench

- Parametrised successor to the scan converter Avalon-MM config bank: N read-only status words plus M byte-writable config words.
- Config words are double-buffered. The CPU writes shadow copies, and a commit request copies all shadows to the active outputs atomically at the next frame_start pulse.
- This prevents mid-frame tearing of timing and scanline config.
- Adds registered readback of all registers, a commit counter and an immediate-update mode.

---
 rtl/sc_config_shadow_regs.sv | 133 +++++++++++++
 tb/tb_sc_config_shadow_regs.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sc_config_shadow_regs.sv
// Avalon-MM config bank: read-only status words plus byte-writable, double-buffered config words.
// Shadow copies become active together at a frame boundary, or immediately in immediate mode.
module sc_config_shadow_regs #(
    parameter int NUM_STATUS = 3,
    parameter int NUM_CONFIG = 11,
    parameter int ADDR_W     = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [ADDR_W-1:0]       avalon_s_address,
    input  logic [31:0]             avalon_s_writedata,
    input  logic [3:0]              avalon_s_byteenable,
    input  logic                    avalon_s_write,
    input  logic                    avalon_s_read,
    input  logic                    avalon_s_chipselect,
    output logic [31:0]             avalon_s_readdata,
    output logic                    avalon_s_readdatavalid,
    output logic                    avalon_s_waitrequest_n,
    input  logic                    frame_start_i,
    input  logic [NUM_STATUS*32-1:0] status_i,
    output logic [NUM_CONFIG*32-1:0] config_o,
    output logic                    commit_pending_o
);

    localparam int CFG_BASE = NUM_STATUS + 1;

    logic [31:0]           addr_ext;
    logic                  wr_en;
    logic                  rd_en;
    logic                  ctrl_wr;
    logic                  commit;
    logic [NUM_CONFIG-1:0] cfg_wr;
    logic [31:0]           ctrl_word;
    logic [31:0]           rd_data;

    logic [31:0] shadow [NUM_CONFIG];
    logic [31:0] active [NUM_CONFIG];
    logic        pending;
    logic        immediate;
    logic [7:0]  commit_cnt;

    logic [31:0] rd_data_p1;
    logic        rd_vld_p1;

    assign addr_ext  = 32'(avalon_s_address);
    assign wr_en     = avalon_s_chipselect && avalon_s_write;
    assign rd_en     = avalon_s_chipselect && avalon_s_read;
    assign ctrl_wr   = wr_en && (addr_ext == 32'd0);
    assign commit    = frame_start_i && pending;
    assign ctrl_word = {16'h0000, commit_cnt, 5'b00000, immediate, pending, 1'b0};

    for (genvar i = 0; i < NUM_CONFIG; i++) begin : g_cfg
        assign cfg_wr[i]              = wr_en && (addr_ext == 32'(CFG_BASE + i));
        assign config_o[32*i +: 32]   = active[i];
    end

    // Readback mux sees pre-write state, so a same-cycle read returns the old value
    always_comb begin
        rd_data = '0;
        if (addr_ext == 32'd0) begin
            rd_data = ctrl_word;
        end
        for (int k = 0; k < NUM_STATUS; k++) begin
            if (addr_ext == 32'(k + 1)) begin
                rd_data = status_i[32*k +: 32];
            end
        end
        for (int i = 0; i < NUM_CONFIG; i++) begin
            if (addr_ext == 32'(CFG_BASE + i)) begin
                rd_data = shadow[i];
            end
        end
    end

    // Commit copies pre-write shadows; immediate-mode bytes override on the same edge
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_CONFIG; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CONFIG; i++) begin
                if (commit) begin
                    active[i] <= shadow[i];
                end
                for (int b = 0; b < 4; b++) begin
                    if (cfg_wr[i] && avalon_s_byteenable[b]) begin
                        shadow[i][8*b +: 8] <= avalon_s_writedata[8*b +: 8];
                        if (immediate) begin
                            active[i][8*b +: 8] <= avalon_s_writedata[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pending    <= 1'b0;
            immediate  <= 1'b0;
            commit_cnt <= 8'h00;
        end else begin
            if (commit) begin
                pending    <= 1'b0;
                commit_cnt <= commit_cnt + 8'd1;
            end else if (ctrl_wr && avalon_s_byteenable[0] && avalon_s_writedata[0]) begin
                pending <= 1'b1;
            end
            if (ctrl_wr && avalon_s_byteenable[0]) begin
                immediate <= avalon_s_writedata[2];
            end
        end
    end

    // Stage p1: registered read response
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_vld_p1  <= 1'b0;
            rd_data_p1 <= '0;
        end else begin
            rd_vld_p1  <= rd_en;
            rd_data_p1 <= rd_en ? rd_data : 32'h0000_0000;
        end
    end

    assign avalon_s_readdata      = rd_data_p1;
    assign avalon_s_readdatavalid = rd_vld_p1;
    assign avalon_s_waitrequest_n = 1'b1;
    assign commit_pending_o       = pending;

endmodule

// File: tb/tb_sc_config_shadow_regs.sv
// Self-checking bench for sc_config_shadow_regs: vector table of byte-lane writes plus
// hand sequences for commit timing, immediate mode, counter wrap and reset.
module tb_sc_config_shadow_regs;

    localparam int NUM_STATUS = 3;
    localparam int NUM_CONFIG = 11;
    localparam int ADDR_W     = 4;

    logic                      clk_i = 1'b0;
    logic                      rst_i = 1'b1;
    logic [ADDR_W-1:0]         avalon_s_address = '0;
    logic [31:0]               avalon_s_writedata = '0;
    logic [3:0]                avalon_s_byteenable = '0;
    logic                      avalon_s_write = 1'b0;
    logic                      avalon_s_read = 1'b0;
    logic                      avalon_s_chipselect = 1'b0;
    logic [31:0]               avalon_s_readdata;
    logic                      avalon_s_readdatavalid;
    logic                      avalon_s_waitrequest_n;
    logic                      frame_start_i = 1'b0;
    logic [NUM_STATUS*32-1:0]  status_i = '0;
    logic [NUM_CONFIG*32-1:0]  config_o;
    logic                      commit_pending_o;

    int passed = 0;
    int total  = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       wdata;
        logic [3:0]        be;
        logic [31:0]       exp;
    } vec_t;
    vec_t vecs[6];

    sc_config_shadow_regs #(
        .NUM_STATUS(NUM_STATUS),
        .NUM_CONFIG(NUM_CONFIG),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .avalon_s_address(avalon_s_address),
        .avalon_s_writedata(avalon_s_writedata),
        .avalon_s_byteenable(avalon_s_byteenable),
        .avalon_s_write(avalon_s_write),
        .avalon_s_read(avalon_s_read),
        .avalon_s_chipselect(avalon_s_chipselect),
        .avalon_s_readdata(avalon_s_readdata),
        .avalon_s_readdatavalid(avalon_s_readdatavalid),
        .avalon_s_waitrequest_n(avalon_s_waitrequest_n),
        .frame_start_i(frame_start_i),
        .status_i(status_i),
        .config_o(config_o),
        .commit_pending_o(commit_pending_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %08h required %08h", name, act, exp);
    endtask

    function automatic logic [31:0] cfg_word(input int k);
        return config_o[32*k +: 32];
    endfunction

    task automatic check_cfg_zero(input string name);
        total++;
        if (config_o === '0) passed++;
        else $display("FAIL %s: config_o got %h required all zero", name, config_o);
    endtask

    // Scoreboard monitor: sample away from the active edge
    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (avalon_s_readdatavalid) begin
                if (exp_q.size() == 0) begin
                    total++;
                    $display("FAIL rvalid_unexpected: got readdatavalid=1 required 0");
                end else begin
                    check("rdata", avalon_s_readdata, exp_q.pop_front());
                end
            end else begin
                check("rdata_idle", avalon_s_readdata, 32'h0);
            end
        end
    end

    task automatic idle_bus();
        avalon_s_chipselect = 1'b0;
        avalon_s_write      = 1'b0;
        avalon_s_read       = 1'b0;
        frame_start_i       = 1'b0;
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic bus_write(input logic [ADDR_W-1:0] a, input logic [31:0] d, input logic [3:0] be,
                             input logic fs);
        avalon_s_chipselect = 1'b1;
        avalon_s_write      = 1'b1;
        avalon_s_address    = a;
        avalon_s_writedata  = d;
        avalon_s_byteenable = be;
        frame_start_i       = fs;
        step();
        idle_bus();
    endtask

    task automatic bus_read(input logic [ADDR_W-1:0] a, input logic [31:0] exp);
        avalon_s_chipselect = 1'b1;
        avalon_s_read       = 1'b1;
        avalon_s_address    = a;
        exp_q.push_back(exp);
        step();
        idle_bus();
    endtask

    task automatic bus_rw(input logic [ADDR_W-1:0] a, input logic [31:0] d, input logic [3:0] be,
                          input logic [31:0] exp_old);
        avalon_s_chipselect = 1'b1;
        avalon_s_read       = 1'b1;
        avalon_s_write      = 1'b1;
        avalon_s_address    = a;
        avalon_s_writedata  = d;
        avalon_s_byteenable = be;
        exp_q.push_back(exp_old);
        step();
        idle_bus();
    endtask

    task automatic frame_pulse();
        frame_start_i = 1'b1;
        step();
        frame_start_i = 1'b0;
    endtask

    initial begin
        vecs[0] = '{4'd4,  32'h12345678, 4'b0101, 32'h00340078};
        vecs[1] = '{4'd5,  32'hAABBCCDD, 4'b1111, 32'hAABBCCDD};
        vecs[2] = '{4'd6,  32'h11223344, 4'b1000, 32'h11000000};
        vecs[3] = '{4'd5,  32'h0000EE00, 4'b0010, 32'hAABBEEDD};
        vecs[4] = '{4'd15, 32'hFFFFFFFF, 4'b1111, 32'h00000000};
        vecs[5] = '{4'd14, 32'hCAFEF00D, 4'b0110, 32'h00FEF000};

        // Reset state
        #1;
        check("rst_rvalid", {31'b0, avalon_s_readdatavalid}, 32'h0);
        check("rst_pending", {31'b0, commit_pending_o}, 32'h0);
        check("waitrequest_n", {31'b0, avalon_s_waitrequest_n}, 32'h1);
        check_cfg_zero("rst_config");
        step(); step();
        rst_i = 1'b0;
        step();

        // CTRL and all config words read 0, back to back
        bus_read(4'd0, 32'h0);
        for (int i = 0; i < NUM_CONFIG; i++) bus_read(4'(NUM_STATUS + 1 + i), 32'h0);

        // Status words sampled at the read cycle
        status_i = {32'h33333333, 32'h22222222, 32'h11111111};
        for (int k = 0; k < NUM_STATUS; k++) bus_read(4'(k + 1), 32'h11111111 * (k + 1));

        // Table of byte-lane writes with readback
        for (int v = 0; v < 6; v++) begin
            bus_write(vecs[v].addr, vecs[v].wdata, vecs[v].be, 1'b0);
            bus_read(vecs[v].addr, vecs[v].exp);
        end
        check_cfg_zero("no_commit_yet");

        // Commit request held over 100 cycles with no frame
        bus_write(4'd0, 32'h1, 4'b0001, 1'b0);
        repeat (100) step();
        check("pending_held", {31'b0, commit_pending_o}, 32'h1);
        check_cfg_zero("cfg_before_frame");
        bus_read(4'd0, 32'h00000002);
        frame_pulse();
        check("commit_w0", cfg_word(0), 32'h00340078);
        check("commit_w1", cfg_word(1), 32'hAABBEEDD);
        check("commit_w2", cfg_word(2), 32'h11000000);
        check("commit_w10", cfg_word(10), 32'h00FEF000);
        check("pending_clr", {31'b0, commit_pending_o}, 32'h0);
        bus_read(4'd0, 32'h00000100);

        // Shadow write in the commit cycle lands in shadow only
        bus_write(4'd7, 32'hA, 4'b1111, 1'b0);
        bus_write(4'd0, 32'h1, 4'b0001, 1'b0);
        bus_write(4'd7, 32'hB, 4'b1111, 1'b1);
        check("same_cycle_active", cfg_word(3), 32'hA);
        bus_read(4'd7, 32'hB);
        bus_write(4'd0, 32'h1, 4'b0001, 1'b0);
        frame_pulse();
        check("second_commit", cfg_word(3), 32'hB);

        // Commit request in the frame cycle with nothing pending: no copy this frame
        bus_write(4'd7, 32'hC, 4'b1111, 1'b0);
        bus_write(4'd0, 32'h1, 4'b0001, 1'b1);
        check("req_on_frame_nocopy", cfg_word(3), 32'hB);
        check("req_on_frame_pend", {31'b0, commit_pending_o}, 32'h1);
        frame_pulse();
        check("req_on_frame_later", cfg_word(3), 32'hC);

        // Repeated request while pending
        bus_write(4'd0, 32'h1, 4'b0001, 1'b0);
        bus_write(4'd0, 32'h1, 4'b0001, 1'b0);
        bus_read(4'd0, 32'h00000402);
        frame_pulse();
        bus_read(4'd0, 32'h00000500);

        // Immediate mode
        bus_write(4'd0, 32'h4, 4'b0001, 1'b0);
        bus_read(4'd0, 32'h00000504);
        bus_write(4'd14, 32'hDEADBEEF, 4'b1111, 1'b0);
        check("imm_w10", cfg_word(10), 32'hDEADBEEF);
        bus_read(4'd0, 32'h00000504);
        bus_write(4'd0, 32'h0, 4'b0010, 1'b0);
        bus_read(4'd0, 32'h00000504);
        bus_rw(4'd5, 32'h99999999, 4'b1111, 32'hAABBEEDD);
        check("imm_rw_w1", cfg_word(1), 32'h99999999);
        bus_read(4'd5, 32'h99999999);
        bus_write(4'd0, 32'h0, 4'b0001, 1'b0);
        bus_read(4'd0, 32'h00000500);

        // Counter wrap: 5 -> 255 -> 0
        for (int n = 0; n < 250; n++) begin
            bus_write(4'd0, 32'h1, 4'b0001, 1'b0);
            frame_pulse();
        end
        bus_read(4'd0, 32'h0000FF00);
        bus_write(4'd0, 32'h1, 4'b0001, 1'b0);
        frame_pulse();
        bus_read(4'd0, 32'h00000000);

        // Reset with a pending commit and a read in flight
        bus_write(4'd4, 32'h55, 4'b1111, 1'b0);
        bus_write(4'd0, 32'h1, 4'b0001, 1'b0);
        check("pre_rst_pending", {31'b0, commit_pending_o}, 32'h1);
        step(); step();
        avalon_s_chipselect = 1'b1;
        avalon_s_read       = 1'b1;
        avalon_s_address    = 4'd0;
        #2;
        rst_i = 1'b1;
        #1;
        check("async_rst_pending", {31'b0, commit_pending_o}, 32'h0);
        check_cfg_zero("async_rst_cfg");
        @(posedge clk_i);
        #1;
        idle_bus();
        check("rst_no_rvalid", {31'b0, avalon_s_readdatavalid}, 32'h0);
        step();
        rst_i = 1'b0;
        step();
        frame_pulse();
        check_cfg_zero("post_rst_frame");
        check("post_rst_pending", {31'b0, commit_pending_o}, 32'h0);
        bus_read(4'd4, 32'h0);
        bus_read(4'd0, 32'h0);

        // Drain the scoreboard within a bounded number of cycles
        for (int w = 0; w < 20 && exp_q.size() != 0; w++) step();
        step();
        if (exp_q.size() != 0) begin
            total++;
            $display("FAIL drain: got %0d outstanding reads required 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
